// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays short square-wave tune sequences on game events.
// Ports: clk, clr (async active-low), jump/status/score/mute in; audio/busy out.
module sfx_sequencer #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        jump,
    input  logic [1:0]  status,
    input  logic [15:0] score,
    input  logic        mute,
    output logic        audio,
    output logic        busy
);

    localparam int unsigned TICK = CLK_HZ / 1000;
    localparam int unsigned PW   = (TICK > 2) ? $clog2(TICK) : 1;
    localparam logic [8:0]  GAP_MS = 9'd10;

    localparam logic [17:0] HP_784  = 18'(CLK_HZ / (2 * 784));
    localparam logic [17:0] HP_988  = 18'(CLK_HZ / (2 * 988));
    localparam logic [17:0] HP_1319 = 18'(CLK_HZ / (2 * 1319));
    localparam logic [17:0] HP_523  = 18'(CLK_HZ / (2 * 523));
    localparam logic [17:0] HP_392  = 18'(CLK_HZ / (2 * 392));
    localparam logic [17:0] HP_330  = 18'(CLK_HZ / (2 * 330));
    localparam logic [17:0] HP_262  = 18'(CLK_HZ / (2 * 262));

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } state_t;

    state_t        state;
    logic [1:0]    prio;
    logic [1:0]    idx;
    logic [PW-1:0] pre;
    logic [8:0]    ms;
    logic [17:0]   tcnt;
    logic          tone;

    logic          jump_q;
    logic [1:0]    status_q;
    logic [15:0]   score_q;

    logic [1:0]    ev;
    logic          take;
    logic          tick;
    logic [17:0]   note_hp;
    logic [8:0]    note_ms;
    logic          last;

    // Highest-priority event this cycle: 3 = over, 2 = score, 1 = jump.
    always_comb begin
        ev = 2'd0;
        if (status == 2'b10 && status_q != 2'b10) begin
            ev = 2'd3;
        end else if (score != score_q && score != 16'd0) begin
            ev = 2'd2;
        end else if (jump && !jump_q && status == 2'b01) begin
            ev = 2'd1;
        end
    end

    // Equal priority restarts the running sequence; lower is dropped.
    assign take = (ev != 2'd0) && (ev >= prio);
    assign tick = (pre == PW'(TICK - 1));

    // Note table indexed by active sequence and note position.
    always_comb begin
        note_hp = HP_784;
        note_ms = 9'd60;
        last    = 1'b1;
        case ({prio, idx})
            {2'd2, 2'd0}: begin note_hp = HP_988;  note_ms = 9'd50;  last = 1'b0; end
            {2'd2, 2'd1}: begin note_hp = HP_1319; note_ms = 9'd100; last = 1'b1; end
            {2'd3, 2'd0}: begin note_hp = HP_523;  note_ms = 9'd150; last = 1'b0; end
            {2'd3, 2'd1}: begin note_hp = HP_392;  note_ms = 9'd150; last = 1'b0; end
            {2'd3, 2'd2}: begin note_hp = HP_330;  note_ms = 9'd150; last = 1'b0; end
            {2'd3, 2'd3}: begin note_hp = HP_262;  note_ms = 9'd300; last = 1'b1; end
            default:      begin note_hp = HP_784;  note_ms = 9'd60;  last = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            prio     <= 2'd0;
            idx      <= 2'd0;
            pre      <= '0;
            ms       <= '0;
            tcnt     <= '0;
            tone     <= 1'b0;
            audio    <= 1'b0;
            busy     <= 1'b0;
            jump_q   <= 1'b0;
            status_q <= 2'b00;
            score_q  <= 16'd0;
        end else begin
            jump_q   <= jump;
            status_q <= status;
            score_q  <= score;
            audio    <= tone & ~mute;

            if (take) begin
                state <= NOTE;
                prio  <= ev;
                idx   <= 2'd0;
                pre   <= '0;
                ms    <= '0;
                tcnt  <= '0;
                tone  <= 1'b0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        prio <= 2'd0;
                        pre  <= '0;
                        ms   <= '0;
                        tcnt <= '0;
                        tone <= 1'b0;
                        busy <= 1'b0;
                    end
                    NOTE: begin
                        if (tick) begin
                            pre <= '0;
                            ms  <= ms + 9'd1;
                        end else begin
                            pre <= pre + PW'(1);
                        end
                        if (tcnt == note_hp - 18'd1) begin
                            tcnt <= '0;
                            tone <= ~tone;
                        end else begin
                            tcnt <= tcnt + 18'd1;
                        end
                        // Note expiry overrides the tone update above.
                        if (tick && ms == note_ms - 9'd1) begin
                            ms   <= '0;
                            tcnt <= '0;
                            tone <= 1'b0;
                            if (last) begin
                                state <= IDLE;
                                prio  <= 2'd0;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        tone <= 1'b0;
                        if (tick) begin
                            pre <= '0;
                            if (ms == GAP_MS - 9'd1) begin
                                ms    <= '0;
                                tcnt  <= '0;
                                idx   <= idx + 2'd1;
                                state <= NOTE;
                            end else begin
                                ms <= ms + 9'd1;
                            end
                        end else begin
                            pre <= pre + PW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        prio  <= 2'd0;
                        busy  <= 1'b0;
                        tone  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Testbench for sfx_sequencer: scoreboard of busy/audio transitions
// produced by a start-time reference model, checked by a separate monitor.
module tb_sfx_sequencer;

    localparam int CLK_HZ = 20_000;
    localparam int TICK   = CLK_HZ / 1000;
    localparam int GAPC   = 10 * TICK;

    logic        clk = 1'b0;
    logic        clr;
    logic        jump;
    logic [1:0]  status;
    logic [15:0] score;
    logic        mute;
    logic        audio;
    logic        busy;

    sfx_sequencer #(.CLK_HZ(CLK_HZ)) dut (
        .clk    (clk),
        .clr    (clr),
        .jump   (jump),
        .status (status),
        .score  (score),
        .mute   (mute),
        .audio  (audio),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit b;
        bit a;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;

    int hp_tab[4][4];
    int dur_tab[4][4];
    int nn[4];

    // reference model state
    bit        mjq;
    bit [1:0]  msq;
    bit [15:0] mscq;
    int        mprio;
    bit        mact;
    int        mseq;
    int        mstart;
    bit        mtone;
    bit        m_busy;
    bit        m_audio;

    function automatic int seq_total(int s);
        int t;
        t = 0;
        for (int i = 0; i < nn[s]; i++) t += dur_tab[s][i] * TICK;
        return t + (nn[s] - 1) * GAPC;
    endfunction

    function automatic bit tone_at(int s, int t0);
        int t;
        int d;
        t = t0;
        for (int i = 0; i < nn[s]; i++) begin
            d = dur_tab[s][i] * TICK;
            if (t < d) return ((t / hp_tab[s][i]) % 2) == 1;
            t -= d;
            if (i < nn[s] - 1) begin
                if (t < GAPC) return 1'b0;
                t -= GAPC;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int ev;
        if (!clr) begin
            mjq = 0; msq = 0; mscq = 0; mprio = 0; mact = 0;
            mtone = 0; m_busy = 0; m_audio = 0;
        end else begin
            ev = 0;
            if (status == 2'b10 && msq != 2'b10) ev = 3;
            else if (score != mscq && score != 16'd0) ev = 2;
            else if (jump && !mjq && status == 2'b01) ev = 1;
            m_audio = mtone & ~mute;
            if (ev != 0 && ev >= mprio) begin
                mact = 1; mseq = ev; mstart = cyc; mprio = ev;
            end else if (mact && (cyc - mstart) >= seq_total(mseq)) begin
                mact = 0; mprio = 0;
            end
            m_busy = mact;
            mtone  = mact ? tone_at(mseq, cyc - mstart) : 1'b0;
            mjq  = jump;
            msq  = status;
            mscq = score;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Expected-transition producer.
    initial begin
        bit [1:0] last_exp;
        bit [1:0] e;
        exp_t     x;
        last_exp = 2'b00;
        wait (mon_en);
        forever begin
            @(negedge clk);
            e = clr ? {m_busy, m_audio} : 2'b00;
            if (e != last_exp) begin
                x.cyc = cyc; x.b = e[1]; x.a = e[0];
                sbq.push_back(x);
                last_exp = e;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT outputs change.
    initial begin
        bit [1:0] last_dut;
        exp_t     x;
        last_dut = 2'b00;
        wait (mon_en);
        forever begin
            @(negedge clk);
            #1;
            if ({busy, audio} != last_dut) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got busy=%0b audio=%0b at cyc %0d, required no change",
                             busy, audio, cyc);
                end else begin
                    x = sbq.pop_front();
                    if (x.cyc != cyc || x.b != busy || x.a != audio) begin
                        failures++;
                        $display("FAIL transition: got busy=%0b audio=%0b at cyc %0d, required busy=%0b audio=%0b at cyc %0d",
                                 busy, audio, cyc, x.b, x.a, x.cyc);
                    end
                end
                last_dut = {busy, audio};
            end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int freq[4][4];
        int r;
        nn[0] = 0; nn[1] = 1; nn[2] = 2; nn[3] = 4;
        freq[1][0] = 784;  dur_tab[1][0] = 60;
        freq[2][0] = 988;  dur_tab[2][0] = 50;
        freq[2][1] = 1319; dur_tab[2][1] = 100;
        freq[3][0] = 523;  dur_tab[3][0] = 150;
        freq[3][1] = 392;  dur_tab[3][1] = 150;
        freq[3][2] = 330;  dur_tab[3][2] = 150;
        freq[3][3] = 262;  dur_tab[3][3] = 300;
        for (int s = 1; s < 4; s++)
            for (int i = 0; i < nn[s]; i++)
                hp_tab[s][i] = CLK_HZ / (2 * freq[s][i]);

        clr = 1'b1; jump = 1'b0; status = 2'b00; score = 16'd0; mute = 1'b0;
        #1 clr = 1'b0;
        wait_cyc(3);
        check("reset_busy", busy, 0);
        check("reset_audio", audio, 0);
        mon_en = 1'b1;
        wait_cyc(1);
        clr = 1'b1;
        wait_cyc(5);

        // Single jump tune.
        status = 2'b01;
        wait_cyc(3);
        jump = 1'b1;
        wait_cyc(1400);

        // Two-note score tune, twice.
        score = 16'd3;
        wait_cyc(3400);
        score = 16'd4;
        wait_cyc(3400);

        // Jump preempted by game over; later events ignored during over.
        jump = 1'b0;
        wait_cyc(2);
        jump = 1'b1;
        wait_cyc(400);
        status = 2'b10;
        wait_cyc(1000);
        score = score + 16'd1;
        jump = 1'b0;
        wait_cyc(2);
        jump = 1'b1;
        wait_cyc(15000);

        // Simultaneous jump and score, muted.
        status = 2'b01;
        jump = 1'b0;
        mute = 1'b1;
        wait_cyc(5);
        jump = 1'b1;
        score = score + 16'd1;
        wait_cyc(3400);
        mute = 1'b0;

        // Asynchronous reset in the middle of the over tune.
        status = 2'b10;
        wait_cyc(3000);
        clr = 1'b0;
        score = 16'd0; status = 2'b00; jump = 1'b0;
        #1;
        check("async_clr_busy", busy, 0);
        check("async_clr_audio", audio, 0);
        wait_cyc(3);
        clr = 1'b1;
        wait_cyc(500);
        check("idle_after_release", busy, 0);

        // Nonzero score present at reset release.
        clr = 1'b0;
        score = 16'd7;
        wait_cyc(3);
        clr = 1'b1;
        wait_cyc(2);
        check("score_at_release_busy", busy, 1);
        wait_cyc(3400);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1: jump = ~jump;
                2: status = 2'($urandom_range(0, 3));
                3: score = score + 16'd1;
                4: score = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                5: mute = ~mute;
                default: begin
                    jump = ~jump;
                    score = score + 16'd1;
                end
            endcase
            wait_cyc($urandom_range(1, 400));
        end

        // Drain: wait for the model to go idle, bounded.
        for (int i = 0; i < 20000 && m_busy; i++) wait_cyc(1);
        wait_cyc(10);
        check("final_busy", busy, 0);
        check("scoreboard_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
